// File: rtl/pam5_dfe_slicer.sv
// PAM5 decision-feedback slicer, one independent DFE per wire pair.
// Single-cycle feedback: each decision feeds the next accepted sample.
module pam5_dfe_slicer #(
  parameter int N_CH   = 4,
  parameter int W      = 8,
  parameter int N_TAPS = 14,
  parameter int TAP_W  = 8,
  parameter int TH1    = 25,
  parameter int TH2    = 76,
  parameter int LEVEL  = 51,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [N_CH*W-1:0]     in_samples,
  input  logic                  tap_wr_en,
  input  logic                  tap_wr_bcast,
  input  logic [CH_W-1:0]       tap_wr_ch,
  input  logic [IDX_W-1:0]      tap_wr_idx,
  input  logic [TAP_W-1:0]      tap_wr_data,
  input  logic                  bypass_fb,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [N_CH*3-1:0]     out_syms,
  output logic [N_CH*W-1:0]     out_filt,
  output logic [N_CH*W-1:0]     out_err
);

  localparam int YW = W + TAP_W + IDX_W + 3;
  localparam logic signed [YW-1:0] SMAX = YW'((1 <<< (W-1)) - 1);
  localparam logic signed [YW-1:0] SMIN = -YW'(1 <<< (W-1));

  logic signed [TAP_W-1:0] taps [N_CH][N_TAPS];
  logic signed [2:0]       hist [N_CH][N_TAPS];

  logic signed [W-1:0]  samp [N_CH];
  logic signed [YW-1:0] fb   [N_CH];
  logic signed [YW-1:0] y    [N_CH];
  logic signed [YW-1:0] ey   [N_CH];
  logic signed [2:0]    d    [N_CH];
  logic                 wr_ok;

  function automatic logic signed [W-1:0] sat(
    input logic signed [YW-1:0] v
  );
    if (v > SMAX) return W'(SMAX);
    if (v < SMIN) return W'(SMIN);
    return W'(v);
  endfunction

  // Flush with a valid sample means that sample sees an empty history.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      samp[c] = signed'(in_samples[(N_CH-c)*W-1 -: W]);
      fb[c] = '0;
      if (!bypass_fb && !flush)
        for (int k = 0; k < N_TAPS; k++)
          fb[c] = fb[c] + YW'(taps[c][k]) * YW'(hist[c][k]);
      y[c] = YW'(samp[c]) - fb[c];
      d[c] = '0;
      unique case (1'b1)
        y[c] > TH2:
          d[c] = 3'sd2;
        y[c] > TH1 && y[c] <= TH2:
          d[c] = 3'sd1;
        y[c] >= -TH1 && y[c] <= TH1:
          d[c] = 3'sd0;
        y[c] >= -TH2 && y[c] < -TH1:
          d[c] = -3'sd1;
        y[c] < -TH2:
          d[c] = -3'sd2;
        default:
          d[c] = '0;
      endcase
      ey[c] = y[c] - YW'(LEVEL * int'(d[c]));
    end
  end

  assign wr_ok = tap_wr_en
    && (32'(tap_wr_idx) < N_TAPS)
    && (tap_wr_bcast || 32'(tap_wr_ch) < N_CH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_syms  <= '0;
      out_filt  <= '0;
      out_err   <= '0;
      for (int c = 0; c < N_CH; c++)
        for (int k = 0; k < N_TAPS; k++) begin
          taps[c][k] <= '0;
          hist[c][k] <= '0;
        end
    end else begin
      out_valid <= in_valid;
      for (int c = 0; c < N_CH; c++) begin
        if (wr_ok && (tap_wr_bcast || CH_W'(c) == tap_wr_ch))
          taps[c][tap_wr_idx] <= signed'(tap_wr_data);
        if (in_valid) begin
          out_syms[(N_CH-c)*3-1 -: 3] <= d[c];
          out_filt[(N_CH-c)*W-1 -: W] <= sat(y[c]);
          out_err[(N_CH-c)*W-1 -: W]  <= sat(ey[c]);
          for (int k = N_TAPS-1; k > 0; k--)
            hist[c][k] <= flush ? 3'sd0 : hist[c][k-1];
          hist[c][0] <= d[c];
        end else if (flush) begin
          for (int k = 0; k < N_TAPS; k++)
            hist[c][k] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pam5_dfe_slicer.sv
// Scoreboard bench for pam5_dfe_slicer with a behavioural DFE model.
// Directed plan items plus randomized tap/sample traffic.
module tb_pam5_dfe_slicer;

  localparam int NC = 4;
  localparam int NT = 14;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_samples = '0;
  logic        tap_wr_en = 1'b0;
  logic        tap_wr_bcast = 1'b0;
  logic [1:0]  tap_wr_ch = '0;
  logic [3:0]  tap_wr_idx = '0;
  logic [7:0]  tap_wr_data = '0;
  logic        bypass_fb = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [11:0] out_syms;
  logic [31:0] out_filt;
  logic [31:0] out_err;

  pam5_dfe_slicer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_samples(in_samples), .tap_wr_en(tap_wr_en),
    .tap_wr_bcast(tap_wr_bcast), .tap_wr_ch(tap_wr_ch),
    .tap_wr_idx(tap_wr_idx), .tap_wr_data(tap_wr_data),
    .bypass_fb(bypass_fb), .flush(flush), .out_valid(out_valid),
    .out_syms(out_syms), .out_filt(out_filt), .out_err(out_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [11:0] syms;
    logic [31:0] filt;
    logic [31:0] err;
  } exp_t;

  exp_t q[$];
  int mt [NC][NT];
  int mh [NC][NT];
  logic [11:0] ls;
  logic [31:0] lf, le;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                  tag, got, got, exp, exp);
  endtask

  function automatic int slice(input int y);
    if (y > 76) return 2;
    if (y > 25) return 1;
    if (y >= -25) return 0;
    if (y >= -76) return -1;
    return -2;
  endfunction

  function automatic int sat8(input int y);
    if (y > 127) return 127;
    if (y < -128) return -128;
    return y;
  endfunction

  function automatic int sym(input int c);
    logic signed [2:0] t;
    t = out_syms[(NC-c)*3-1 -: 3];
    return int'(t);
  endfunction

  function automatic int filt(input int c);
    logic signed [7:0] t;
    t = out_filt[(NC-c)*8-1 -: 8];
    return int'(t);
  endfunction

  function automatic int err(input int c);
    logic signed [7:0] t;
    t = out_err[(NC-c)*8-1 -: 8];
    return int'(t);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < NT; k++) begin
        mt[c][k] = 0;
        mh[c][k] = 0;
      end
    ls = '0; lf = '0; le = '0;
  endtask

  task automatic set_tap(input logic bc, input int ch,
                         input int idx, input int data);
    tap_wr_en = 1'b1;
    tap_wr_bcast = bc;
    tap_wr_ch = 2'(ch);
    tap_wr_idx = 4'(idx);
    tap_wr_data = 8'(data);
  endtask

  // One clock: drive, predict, push; then pop and compare after the edge.
  task automatic step(input logic v, input int s0, input int s1,
                      input int s2, input int s3,
                      input logic fl, input logic bp);
    int s [NC];
    int fb, y, d;
    exp_t e;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    in_valid = v;
    flush = fl;
    bypass_fb = bp;
    for (int c = 0; c < NC; c++)
      in_samples[(NC-c)*8-1 -: 8] = 8'(s[c]);
    e = '0;
    if (v) begin
      for (int c = 0; c < NC; c++) begin
        fb = 0;
        if (!bp && !fl)
          for (int k = 0; k < NT; k++) fb += mt[c][k] * mh[c][k];
        y = s[c] - fb;
        d = slice(y);
        e.syms[(NC-c)*3-1 -: 3] = 3'(d);
        e.filt[(NC-c)*8-1 -: 8] = 8'(sat8(y));
        e.err[(NC-c)*8-1 -: 8]  = 8'(sat8(y - 51 * d));
        for (int k = NT-1; k > 0; k--) mh[c][k] = fl ? 0 : mh[c][k-1];
        mh[c][0] = d;
      end
      q.push_back(e);
    end else if (fl) begin
      for (int c = 0; c < NC; c++)
        for (int k = 0; k < NT; k++) mh[c][k] = 0;
    end
    if (tap_wr_en && int'(tap_wr_idx) < NT)
      for (int c = 0; c < NC; c++)
        if (tap_wr_bcast || c == int'(tap_wr_ch))
          mt[c][tap_wr_idx] = int'($signed(tap_wr_data));
    @(posedge clock);
    #1;
    tap_wr_en = 1'b0;
    tap_wr_bcast = 1'b0;
    chk("valid", int'(out_valid), int'(v));
    if (v) begin
      if (q.size() == 0) begin
        chk("q_empty", 1, 0);
      end else begin
        e = q.pop_front();
        ls = e.syms; lf = e.filt; le = e.err;
      end
    end
    chk("syms", int'(out_syms), int'(ls));
    chk("filt", int'(out_filt), int'(lf));
    chk("err", int'(out_err), int'(le));
  endtask

  task automatic bubble(input logic fl);
    step(1'b0, 0, 0, 0, 0, fl, 1'b0);
  endtask

  task automatic ch1(input int s, input logic fl, input logic bp);
    step(1'b1, 0, s, 0, 0, fl, bp);
  endtask

  int thr_s [8] = '{25, 26, 76, 77, -25, -26, -76, -77};
  int thr_d [8] = '{0, 1, 1, 2, 0, -1, -1, -2};

  initial begin
    model_clear();
    #12;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_syms", int'(out_syms), 0);
    chk("rst_filt", int'(out_filt), 0);
    chk("rst_err", int'(out_err), 0);
    @(negedge clock);
    reset = 1'b1;

    step(1'b1, 101, 51, 0, -52, 1'b0, 1'b0);
    chk("basic_d0", sym(0), 2);
    chk("basic_d1", sym(1), 1);
    chk("basic_d2", sym(2), 0);
    chk("basic_d3", sym(3), -1);
    chk("basic_e0", err(0), -1);
    chk("basic_e3", err(3), -1);

    for (int i = 0; i < 8; i++) begin
      step(1'b1, thr_s[i], 0, 0, 0, 1'b0, 1'b0);
      chk("thresh", sym(0), thr_d[i]);
    end

    set_tap(1'b0, 1, 0, 20);
    bubble(1'b0);
    set_tap(1'b0, 1, 1, 10);
    bubble(1'b1);
    ch1(101, 1'b0, 1'b0);
    chk("fb_a", sym(1), 2);
    ch1(60, 1'b0, 1'b0);
    chk("fb_b", sym(1), 0);
    chk("fb_b_filt", filt(1), 20);
    ch1(60, 1'b0, 1'b0);
    chk("fb_c", sym(1), 1);
    chk("fb_c_filt", filt(1), 40);
    bubble(1'b1);
    ch1(101, 1'b0, 1'b1);
    chk("byp_a", sym(1), 2);
    ch1(60, 1'b0, 1'b1);
    chk("byp_b", sym(1), 1);
    ch1(60, 1'b0, 1'b1);
    chk("byp_c", sym(1), 1);

    bubble(1'b1);
    ch1(101, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bubble(1'b0);
      chk("bub_hold", sym(1), 2);
    end
    ch1(60, 1'b0, 1'b0);
    chk("bub_d", sym(1), 0);
    chk("bub_filt", filt(1), 20);

    set_tap(1'b0, 2, 0, -127);
    bubble(1'b1);
    step(1'b1, 0, 0, 127, 0, 1'b0, 1'b0);
    chk("sat_a", sym(2), 2);
    step(1'b1, 0, 0, 127, 0, 1'b0, 1'b0);
    chk("sat_d", sym(2), 2);
    chk("sat_filt", filt(2), 127);
    chk("sat_err", err(2), 127);

    bubble(1'b1);
    set_tap(1'b1, 3, 0, 50);
    step(1'b1, 101, 101, 101, 101, 1'b0, 1'b0);
    for (int c = 0; c < NC; c++) chk("sim_a", sym(c), 2);
    step(1'b1, 100, 100, 100, 100, 1'b1, 1'b0);
    for (int c = 0; c < NC; c++) chk("sim_flush", sym(c), 2);
    step(1'b1, 100, 100, 100, 100, 1'b0, 1'b0);
    for (int c = 0; c < NC; c++) chk("sim_c", sym(c), 0);

    set_tap(1'b0, 0, 14, 99);
    bubble(1'b0);
    set_tap(1'b0, 0, 15, 99);
    bubble(1'b0);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        set_tap(1'($urandom_range(0, 1)), $urandom_range(0, 3),
                $urandom_range(0, 15), $urandom_range(0, 255) - 128);
      step(1'($urandom_range(0, 4) != 0),
           $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
           $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
           1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 7) == 0));
    end

    in_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_syms", int'(out_syms), 0);
    chk("mid_rst_filt", int'(out_filt), 0);
    @(negedge clock);
    reset = 1'b1;
    model_clear();
    q.delete();
    step(1'b1, 90, -90, 30, -30, 1'b0, 1'b0);
    step(1'b1, 90, -90, 30, -30, 1'b0, 1'b0);
    chk("post_rst_d0", sym(0), 2);
    chk("post_rst_d1", sym(1), -2);
    chk("q_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pam5_dfe_slicer.md
Name: pam5_dfe_slicer

Overview:
- Parametrised per-channel PAM5 decision-feedback slicer for the 1000BASE-T receive path.
- Sits after the FFE and before symbol decode.
- Per channel: subtracts a tap-weighted sum of its own past decisions from the incoming sample, slices the result to {-2..2}, and reports the slicer error for tap adaptation.
- Generalises the fixed 4-channel decoder with a runtime tap-write port, a feedback-bypass mode, history flush and valid bubbles.

Parameters:
- N_CH, 4, number of parallel wire-pair channels
- W, 8, signed sample width; also the filtered and error output width
- N_TAPS, 14, postcursor feedback taps per channel
- TAP_W, 8, signed tap width
- TH1, 25, inner slicer threshold (magnitude)
- TH2, 76, outer slicer threshold (magnitude)
- LEVEL, 51, ideal amplitude of symbol +1, used for the error term

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- in_valid  in  1  samples valid this cycle
- in_samples  in  N_CH*W  signed samples; ch0 in MSBs
- tap_wr_en  in  1  tap write strobe
- tap_wr_bcast  in  1  write the tap to all channels, ignoring tap_wr_ch
- tap_wr_ch  in  clog2(N_CH)  target channel
- tap_wr_idx  in  clog2(N_TAPS)  tap index; 0 = weight on d[n-1]
- tap_wr_data  in  TAP_W  signed tap value
- bypass_fb  in  1  force the feedback sum to 0
- flush  in  1  clear decision history
- out_valid  out  1  outputs valid
- out_syms  out  N_CH*3  signed 3-bit decisions; ch0 at [N_CH*3-1 -: 3]
- out_filt  out  N_CH*W  saturated filtered value per channel
- out_err  out  N_CH*W  saturated filt - LEVEL*d per channel

Behaviour:
- Reset (reset=0, async): all outputs 0; all taps 0; all history 0. Reset mid-stream discards in-flight data. The first in_valid after release is processed with zero history.
- Per channel c, for each accepted sample:
  - fb = sum over k=0..N_TAPS-1 of tap[c][k] * hist[c][k], full precision.
  - fb = 0 if bypass_fb.
  - y = sample - fb at full internal width (≥ W+TAP_W+clog2(N_TAPS)+3 bits).
- Slicer on full-precision y:
  - y > TH2 → +2
  - y > TH1 → +1
  - -TH1 ≤ y ≤ TH1 → 0
  - -TH2 ≤ y < -TH1 → -1
  - y < -TH2 → -2
  - Exact equality to ±TH1 or ±TH2 follows these inequalities.
- out_filt = y saturated to [-2^(W-1), 2^(W-1)-1].
- out_err = (y - LEVEL*d) saturated to W bits.
- Latency: one cycle. in_valid at edge t produces out_valid=1 and data registered at edge t+1.
- in_valid=0: out_valid=0 next cycle; out_syms/out_filt/out_err hold their last values; history unchanged (bubbles do not advance the feedback line).
- History: on accept, hist[c][k] ← hist[c][k-1] for k≥1, and hist[c][0] ← d. History always stores the decision, even in bypass mode.
- Feedback loop is single-cycle. d[n] is available to sample n+1 on the next accepted cycle without stall.
- Tap write: effective for samples accepted on the cycle after the strobe. A write coincident with in_valid uses the old taps for that sample.
  - tap_wr_bcast=1 writes index tap_wr_idx in every channel.
  - tap_wr_idx ≥ N_TAPS: write ignored.
  - tap_wr_ch ≥ N_CH without bcast: write ignored.
- flush without in_valid: all history zeroed next cycle.
- flush with in_valid: that sample uses zero history, then history = {d, 0, ..., 0}.
- Taps are not cleared by flush; only reset clears them.
- Channels are fully independent; no cross-channel state.

Test Plan:
- Reset release, taps 0, samples {101,51,0,-52} with in_valid → next cycle out_valid=1, out_syms ch0..3 = {+2,+1,0,-1}, out_err = {-1,0,0,-1}.
- Threshold edges, ch0 with zero taps: samples 25, 26, 76, 77, -25, -26, -76, -77 → decisions 0, +1, +1, +2, 0, -1, -1, -2.
- Write ch1 tap0=20 and tap1=10. Feed ch1: 101 → +2; then 60 → y=60-40=20, decision 0; then 60 → y=60-0-20=40, decision +1. Repeat with bypass_fb=1 → decisions +2, +1, +1.
- Bubble: feed 101, hold in_valid=0 for 3 cycles, feed 60 on ch1 with tap0=20 → y=20, decision 0 (history not advanced by bubbles); out_valid low during the bubbles with outputs held.
- Saturation, ch2 tap0=-127: feed 127 (d=+2), then 127 → y=381 → out_filt=127, decision +2, out_err=127.
- Simultaneous events: broadcast tap write tap0=50 in the same cycle as sample 101 on all channels → all decisions +2 (old taps used). Next sample 100 with flush=1 → fb=0, decision +2. The sample after that, 100 → y=0, decision 0.
